// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP layer scheduler.
// Contents: scheduler state encoding, wait-counter width, statistics counter width.
package mlp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    localparam int unsigned TIMEOUT_W = 16;
    localparam int unsigned CNT_W     = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/mlp_rr_arbiter2.sv
// Two-request round-robin arbiter with a registered last-grant pointer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req       : request bits (already qualified by the caller)
//   accept    : a grant was taken this cycle; pointer moves to the winner
//   grant_c   : one-hot grant (combinational)
//   winner_c  : index of the granted port (combinational)
module mlp_rr_arbiter2
    import mlp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant_c,
    output logic       winner_c
);

    logic last_grant;

    // Winner select: a lone requester wins; on a tie the port not granted last wins.
    always_comb begin
        winner_c = 1'b0;
        grant_c  = 2'b00;
        case (req)
            2'b01:   winner_c = 1'b0;
            2'b10:   winner_c = 1'b1;
            2'b11:   winner_c = ~last_grant;
            default: winner_c = 1'b0;
        endcase
        if (req != 2'b00) begin
            grant_c[winner_c] = 1'b1;
        end
    end

    // Pointer starts at port 1 so port 0 takes the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= winner_c;
        end
    end

endmodule

// File: rtl/mlp_layer_scheduler.sv
// Sequencer and two-port arbiter for a shared mlp_hidden_layer datapath.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/req_ready/req_vec  : per-port request channel (port 0 host, port 1 loader)
//   resp_valid/resp_ready        : response handshake
//   resp_data/resp_tag/resp_err  : layer output, requesting port, timeout flag
//   layer_bus_in/layer_start     : drive the datapath input vector and start pulse
//   layer_out/layer_done         : datapath result and done level
//   busy                         : scheduler not idle
//   done_count/timeout_count     : saturating completion / timeout statistics
module mlp_layer_scheduler
    import mlp_pkg::*;
#(
    parameter int unsigned IN_DIM      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ACC_W       = 16,
    parameter int unsigned HIDDEN_SIZE = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [2*DATA_W*IN_DIM-1:0]    req_vec,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ACC_W*HIDDEN_SIZE-1:0]  resp_data,
    output logic                          resp_tag,
    output logic                          resp_err,
    output logic [DATA_W*IN_DIM-1:0]      layer_bus_in,
    output logic                          layer_start,
    input  logic [ACC_W*HIDDEN_SIZE-1:0]  layer_out,
    input  logic                          layer_done,
    output logic                          busy,
    output logic [CNT_W-1:0]              done_count,
    output logic [CNT_W-1:0]              timeout_count
);

    localparam int unsigned VEC_W = DATA_W * IN_DIM;
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIM = TIMEOUT_W'(TIMEOUT_CYC);

    sched_state_t         state;
    sched_state_t         next_state;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [1:0]           arb_req_c;
    logic [1:0]           grant_c;
    logic                 winner_c;
    logic                 accept_c;
    logic                 done_hit_c;
    logic                 timeout_hit_c;

    // Requests are only offered to the arbiter while idle.
    assign arb_req_c = (state == IDLE) ? req_valid : 2'b00;

    mlp_rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (arb_req_c),
        .accept   (accept_c),
        .grant_c  (grant_c),
        .winner_c (winner_c)
    );

    assign req_ready = grant_c;
    assign accept_c  = |(req_valid & grant_c);

    // A done seen in the first WAIT cycle is left over from the previous run.
    assign done_hit_c    = (state == WAIT) && layer_done && (wait_cnt != '0);
    assign timeout_hit_c = (state == WAIT) && !done_hit_c && (wait_cnt == TIMEOUT_LIM);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept_c) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (done_hit_c || timeout_hit_c) next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs, capture registers and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            layer_start   <= 1'b0;
            resp_valid    <= 1'b0;
            busy          <= 1'b0;
            wait_cnt      <= '0;
            layer_bus_in  <= '0;
            resp_tag      <= 1'b0;
            resp_data     <= '0;
            resp_err      <= 1'b0;
            done_count    <= '0;
            timeout_count <= '0;
        end else begin
            layer_start <= (next_state == START);
            resp_valid  <= (next_state == RESP);
            busy        <= (next_state != IDLE);

            if (state == START) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + TIMEOUT_W'(1);
            end

            if (accept_c) begin
                layer_bus_in <= winner_c ? req_vec[VEC_W +: VEC_W] : req_vec[0 +: VEC_W];
                resp_tag     <= winner_c;
            end

            if (done_hit_c) begin
                resp_data <= layer_out;
                resp_err  <= 1'b0;
                if (done_count != CNT_MAX) begin
                    done_count <= done_count + CNT_W'(1);
                end
            end else if (timeout_hit_c) begin
                resp_data <= '0;
                resp_err  <= 1'b1;
                if (timeout_count != CNT_MAX) begin
                    timeout_count <= timeout_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mlp_layer_scheduler.sv
// Self-checking bench for mlp_layer_scheduler: requester drivers, a behavioural
// hidden-layer model and a response scoreboard, all advanced on the falling edge.
module tb_mlp_layer_scheduler;

    localparam int unsigned IN_DIM      = 4;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ACC_W       = 16;
    localparam int unsigned HIDDEN_SIZE = 2;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int unsigned VEC_W       = DATA_W * IN_DIM;
    localparam int unsigned OUT_W       = ACC_W * HIDDEN_SIZE;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_NEVER  = 1;
    localparam int MODE_STALE  = 2;

    typedef struct packed {
        logic             tag;
        logic             err;
        logic [OUT_W-1:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         req_valid = 2'b00;
    logic [1:0]         req_ready;
    logic [2*VEC_W-1:0] req_vec = '0;
    logic               resp_valid;
    logic               resp_ready = 1'b1;
    logic [OUT_W-1:0]   resp_data;
    logic               resp_tag;
    logic               resp_err;
    logic [VEC_W-1:0]   layer_bus_in;
    logic               layer_start;
    logic [OUT_W-1:0]   layer_out = '0;
    logic               layer_done = 1'b0;
    logic               busy;
    logic [15:0]        done_count;
    logic [15:0]        timeout_count;

    mlp_layer_scheduler #(
        .IN_DIM      (IN_DIM),
        .DATA_W      (DATA_W),
        .ACC_W       (ACC_W),
        .HIDDEN_SIZE (HIDDEN_SIZE),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_vec       (req_vec),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_tag      (resp_tag),
        .resp_err      (resp_err),
        .layer_bus_in  (layer_bus_in),
        .layer_start   (layer_start),
        .layer_out     (layer_out),
        .layer_done    (layer_done),
        .busy          (busy),
        .done_count    (done_count),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference hidden layer: two neurons with fixed integer weights.
    function automatic logic [OUT_W-1:0] layer_fn(input logic [VEC_W-1:0] v);
        logic [15:0] n0;
        logic [15:0] n1;
        n0 = 16'(3 * int'(v[7:0]) + 4 * int'(v[15:8]) + 5 * int'(v[23:16]) + 6 * int'(v[31:24]));
        n1 = 16'(4 * int'(v[7:0]) + 3 * int'(v[15:8]) + 2 * int'(v[23:16]) + int'(v[31:24]));
        return {n1, n0};
    endfunction

    function automatic logic [1:0] grant_model(input logic [1:0] v, input logic last);
        case (v)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return last ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    logic [VEC_W-1:0] pq[2][$];
    exp_t             exp_q[$];
    int               grants[$];
    logic [1:0]       acc = 2'b00;
    logic             rhs = 1'b0;
    logic             idle_m = 1'b1;
    logic             rr_last = 1'b1;
    logic             do_reset = 1'b0;
    logic             bp_arm = 1'b0;
    logic             rv_prev = 1'b0;
    logic             ls_prev = 1'b0;
    int               mode = MODE_NORMAL;
    int               lat = 5;
    int               hold = 0;
    int               k = 0;
    int               starts = 0;
    int               start_cyc = 0;
    int               acc_cyc = 0;
    int               rise_cyc = 0;
    int               rhs_cyc = 0;
    int               m_done = 0;
    int               m_to = 0;
    logic [VEC_W-1:0] last_vec = '0;
    logic [OUT_W-1:0] snap_data = '0;
    logic             snap_tag = 1'b0;
    logic             snap_err = 1'b0;

    function automatic int exp_rise_lat();
        if (mode == MODE_NEVER) return int'(TIMEOUT_CYC) + 2;
        if (mode == MODE_STALE) return 6;
        return lat + 1;
    endfunction

    // Cycle engine: consume last cycle's handshakes, model the layer, drive inputs.
    always @(negedge clk) begin
        int   p;
        exp_t e;

        if (acc != 2'b00) begin
            p        = acc[1] ? 1 : 0;
            last_vec = pq[p].pop_front();
            e.tag    = p[0];
            e.err    = (mode == MODE_NEVER);
            e.data   = e.err ? '0 : layer_fn(last_vec);
            exp_q.push_back(e);
            grants.push_back(p);
            rr_last  = p[0];
            idle_m   = 1'b0;
            acc_cyc  = cyc - 1;
            if (bp_arm && p == 1) begin
                chk("bp_accept_gap", 64'(acc_cyc - rhs_cyc), 64'd1);
                bp_arm = 1'b0;
            end
        end
        if (rhs) begin
            rhs_cyc = cyc - 1;
            idle_m  = 1'b1;
        end

        if (rst) begin
            chk("rst_bus_in", 64'(layer_bus_in), 64'd0);
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_resp_data", 64'(resp_data), 64'd0);
            chk("rst_resp_tag", 64'(resp_tag), 64'd0);
            chk("rst_resp_err", 64'(resp_err), 64'd0);
            chk("rst_layer_start", 64'(layer_start), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done_count", 64'(done_count), 64'd0);
            chk("rst_timeout_count", 64'(timeout_count), 64'd0);
            rst = 1'b0;
        end

        if (do_reset) begin
            rst      = 1'b1;
            do_reset = 1'b0;
            pq[0].delete();
            pq[1].delete();
            exp_q.delete();
            idle_m   = 1'b1;
            rr_last  = 1'b1;
            m_done   = 0;
            m_to     = 0;
            bp_arm   = 1'b0;
        end

        if (layer_start) begin
            chk("start_pulse_width", 64'(ls_prev), 64'd0);
            chk("start_after_accept", 64'(cyc - acc_cyc), 64'd1);
            chk("bus_in", 64'(layer_bus_in), 64'(last_vec));
            starts++;
            k         = 0;
            start_cyc = cyc;
        end else begin
            k++;
        end
        ls_prev = layer_start;

        case (mode)
            MODE_NORMAL: begin
                layer_done = (k >= lat);
                if (k == lat) layer_out = layer_fn(layer_bus_in);
            end
            MODE_NEVER: layer_done = 1'b0;
            default: begin
                // Done left high from the previous run through the first WAIT cycle.
                if (k == 2) begin
                    layer_done = 1'b0;
                end else if (k == 5) begin
                    layer_done = 1'b1;
                    layer_out  = layer_fn(layer_bus_in);
                end
            end
        endcase

        if (resp_valid && !rv_prev) begin
            rise_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("spurious_resp", 64'(resp_valid), 64'd0);
            end else begin
                chk("resp_latency", 64'(cyc - start_cyc), 64'(exp_rise_lat()));
                if (exp_q[0].err) m_to++;
                else m_done++;
            end
            snap_data = resp_data;
            snap_tag  = resp_tag;
            snap_err  = resp_err;
        end else if (resp_valid) begin
            chk("hold_data", 64'(resp_data), 64'(snap_data));
            chk("hold_tag", 64'(resp_tag), 64'(snap_tag));
            chk("hold_err", 64'(resp_err), 64'(snap_err));
        end
        rv_prev = resp_valid;

        resp_ready = !(resp_valid && (cyc - rise_cyc) < hold);

        for (int i = 0; i < 2; i++) begin
            req_valid[i] = (pq[i].size() > 0) && !rst;
            if (pq[i].size() > 0) req_vec[i*VEC_W +: VEC_W] = pq[i][0];
        end

        #1;
        if (!rst) begin
            chk("req_ready", 64'(req_ready),
                64'(idle_m ? grant_model(req_valid, rr_last) : 2'b00));
            chk("busy", 64'(busy), 64'(!idle_m));
            acc = req_valid & req_ready;
            rhs = resp_valid & resp_ready;
            if (rhs) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 64'(rhs), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", 64'(resp_data), 64'(e.data));
                    chk("resp_tag", 64'(resp_tag), 64'(e.tag));
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                    chk("done_count", 64'(done_count), 64'(m_done));
                    chk("timeout_count", 64'(timeout_count), 64'(m_to));
                end
            end
        end else begin
            acc = 2'b00;
            rhs = 1'b0;
        end
    end

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (!(pq[0].size() == 0 && pq[1].size() == 0 && exp_q.size() == 0 && idle_m)
               && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        if (n >= max_cyc) chk("drain_timeout", 64'(n), 64'd0);
    endtask

    initial begin
        int s0;
        int n;

        repeat (3) @(posedge clk);

        // Single request, no contention.
        mode = MODE_NORMAL;
        lat  = 5;
        pq[0].push_back(32'h04030201);
        wait_drain(200);
        chk("t1_start_pulses", 64'(starts), 64'd1);

        // Both ports contending, four requests each, from a fresh reset.
        do_reset = 1'b1;
        repeat (3) @(posedge clk);
        grants.delete();
        lat = 3;
        for (int i = 0; i < 4; i++) begin
            pq[0].push_back(32'h10203040 + 32'(i));
            pq[1].push_back(32'h0a141e28 + 32'(i * 3));
        end
        wait_drain(400);
        chk("t2_grant_count", 64'(grants.size()), 64'd8);
        for (int i = 0; i < grants.size(); i++) begin
            chk("t2_grant_order", 64'(grants[i]), 64'(i % 2));
        end

        // Timeout: the layer never reports done.
        mode = MODE_NEVER;
        pq[1].push_back(32'h0a0b0c0d);
        wait_drain(200);

        // Backpressure on the response with port 1 waiting.
        mode = MODE_NORMAL;
        lat  = 2;
        hold = 10;
        pq[0].push_back(32'h01020304);
        n = 0;
        while (idle_m && n < 100) begin
            @(posedge clk);
            n++;
        end
        bp_arm = 1'b1;
        pq[1].push_back(32'h05050505);
        wait_drain(300);
        hold = 0;
        chk("t4_port1_accepted", 64'(bp_arm), 64'd0);

        // Stale done from the previous run must be ignored.
        lat = 4;
        pq[0].push_back(32'h11223344);
        wait_drain(200);
        mode = MODE_STALE;
        pq[1].push_back(32'h05060708);
        wait_drain(200);

        // Reset while waiting on the layer, then a fresh tie.
        mode = MODE_NORMAL;
        lat  = 10;
        s0   = starts;
        pq[0].push_back(32'h01010101);
        n = 0;
        while (starts == s0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("t6_started", 64'(starts - s0), 64'd1);
        repeat (3) @(posedge clk);
        do_reset = 1'b1;
        repeat (30) @(posedge clk);
        grants.delete();
        lat = 3;
        pq[1].push_back(32'h02030405);
        pq[0].push_back(32'h06070809);
        wait_drain(200);
        chk("t6_grant_count", 64'(grants.size()), 64'd2);
        if (grants.size() > 0) chk("t6_first_grant", 64'(grants[0]), 64'd0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/mlp_layer_scheduler.md
# mlp_layer_scheduler

Sequencer and two-port arbiter for one shared `mlp_hidden_layer` datapath. Two requesters submit input vectors: port 0 is the host AVMM bridge and port 1 is the streaming loader. The scheduler grants them round-robin, loads the vector, issues a one-cycle start, and waits for done under a timeout. It then returns the layer output with a requester tag over a valid/ready response channel. It sits between the bus-facing logic and the hidden-layer instance and replaces direct start/bus_in poking.

## Interface
- `IN_DIM`, default 4: input vector length.
- `DATA_W`, default 8: input element width.
- `ACC_W`, default 16: output element width.
- `HIDDEN_SIZE`, default 2: number of hidden neurons.
- `TIMEOUT_CYC`, default 1024: maximum WAIT cycles before abort; valid range 2..65535.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  2: per-port request valid.
- `req_ready`  out  2: per-port accept (combinational from state and arbiter).
- `req_vec`  in  2*DATA_W*IN_DIM: port p vector at `[p*DATA_W*IN_DIM +: DATA_W*IN_DIM]`.
- `resp_valid`  out  1: response available.
- `resp_ready`  in  1: response consumed.
- `resp_data`  out  ACC_W*HIDDEN_SIZE: captured layer output.
- `resp_tag`  out  1: index of the port that issued the request.
- `resp_err`  out  1: 1 means the request timed out.
- `layer_bus_in`  out  DATA_W*IN_DIM: drives the datapath `bus_in`.
- `layer_start`  out  1: one-cycle start pulse.
- `layer_out`  in  ACC_W*HIDDEN_SIZE: datapath `hidden_out_flat`.
- `layer_done`  in  1: datapath `hidden_all_done`, treated as a level.
- `busy`  out  1: high whenever state is not IDLE.
- `done_count`  out  16: completed requests, saturating.
- `timeout_count`  out  16: timed-out requests, saturating.

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- **IDLE:** the arbiter picks a winner among asserted `req_valid` bits.
  - `req_ready[winner]=1`; the other bit is 0.
  - On handshake: capture `req_vec` slice into `layer_bus_in`, capture the tag, update the round-robin pointer to the winner, go to START.
- **Arbitration:**
  - Exactly one valid port: that port wins.
  - Both ports valid: the port not granted last wins.
  - After reset the pointer is set so port 0 wins the first tie.
- **START:** `layer_start=1` for exactly this cycle. Clear the wait counter. Go to WAIT.
- **WAIT:** the wait counter increments every cycle.
  - `layer_done` is ignored while counter==0, which masks a stale done from the previous run.
  - Done sampled high with counter≥1: capture `layer_out` into `resp_data`, set `resp_err=0`, increment `done_count`, go to RESP.
  - Counter reaches `TIMEOUT_CYC` with no done: set `resp_data=0`, `resp_err=1`, increment `timeout_count`, go to RESP.
  - If both conditions occur in the same cycle, done wins.
- **RESP:** `resp_valid=1`, and `resp_data`, `resp_tag` and `resp_err` are held stable. On `resp_valid&&resp_ready`, go to IDLE.
- `layer_bus_in` holds its value from acceptance until the next acceptance; it is never cleared between requests.
- Both counters saturate at 16'hFFFF.
- **Reset at any point:**
  - State returns to IDLE.
  - All outputs become 0: `layer_bus_in`, `resp_*`, `layer_start`, both counters.
  - The round-robin pointer is reset.
  - Any in-flight request is dropped with no response.

## Timing
- Handshake at cycle T: `layer_start` is high in T+1; WAIT begins in T+2.
- If `layer_done` is first high in cycle D (D ≥ T+3), `resp_valid` rises in D+1.
- Minimum accept-to-`resp_valid` latency is 4 cycles.
- Timeout: `resp_valid` rises `TIMEOUT_CYC`+2 cycles after `layer_start`.
- After the RESP handshake in cycle R, the next acceptance can occur at R+1 at the earliest (the cycle in IDLE).
- `req_ready` is 0 in all states other than IDLE.
- `req_valid` must be held by the requester until accepted.

## Structure
- Shared package `mlp_pkg`:
  - `sched_state_t` enum (IDLE/START/WAIT/RESP);
  - `TIMEOUT_W` localparam = 16;
  - counter width constant.
- Sub-module `mlp_rr_arbiter2`: a 2-request round-robin arbiter with a registered last-grant pointer and an update-on-accept input.
- FSM, capture registers and counters live in the top module.

## Test plan
- **Single request, no contention:** port 0 requests vector 0x04030201; a layer model raises done 5 cycles after start with out=0x00140032. Expect `resp_data`=0x00140032, tag=0, err=0, `done_count`=1, exactly one `layer_start` pulse.
- **Simultaneous requests:** both ports held valid for 4 requests each. Expect grant order 0,1,0,1,…, tags alternating, and no `req_ready` outside IDLE.
- **Timeout:** `TIMEOUT_CYC`=16 and the model never asserts done. Expect `resp_valid` 18 cycles after start, err=1, data=0, `timeout_count`=1.
- **Backpressure:** `resp_ready` held low for 10 cycles. Expect the response stable for all 10 cycles, `req_ready`=0 throughout, and acceptance of the pending port 1 one cycle after the handshake.
- **Stale done:** `layer_done` stuck high from the previous run, dropping 1 cycle after start and re-rising 3 cycles later. Expect the response taken from the re-rise, not from the first WAIT cycle.
- **Reset mid-WAIT:** assert `rst` 3 cycles into WAIT. Expect all outputs 0 the next cycle, no response emitted, and the first post-reset tie granted to port 0.
